gmii_tx_arbiter: RTL and testbench
==================================

Name: gmii_tx_arbiter

Overview:
- Shares one GMII transmit port (txd/tx_en/tx_er, on the 125 MHz GMII tx clock) among NREQ frame sources.
- Arbitration is round-robin. The block generates preamble and SFD, streams the granted source's payload, and enforces the inter-frame gap.
- It sits between packet builders and the sgmii_ethernet_pcs_pma GMII input. link_up is driven from the PCS/PMA resetdone.
- Sources supply destination MAC through FCS. The block adds nothing after the payload.

Parameters:
- NREQ, 2, number of requesters (1..8).
- IFG_CYCLES, 12, minimum tx_en-low cycles between frames (>=2).

Ports:
- clk  in  1  GMII tx clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- link_up  in  1  PCS/PMA ready; no new grant while low.
- req_valid  in  NREQ  per-source byte valid.
- req_data  in  8*NREQ  per-source byte; source i uses bits [8i+7:8i].
- req_last  in  NREQ  marks the final byte of a frame.
- req_ready  out  NREQ  byte accepted when valid&ready.
- grant  out  NREQ  one-hot owner of the current frame; 0 when idle.
- gmii_txd  out  8  to PCS.
- gmii_tx_en  out  1  to PCS.
- gmii_tx_er  out  1  to PCS.
- underrun  out  1  one-cycle pulse when a frame is aborted.
- frame_cnt  out  16  completed (non-aborted) frames, wraps at 0xFFFF->0.

Behaviour:
- Reset values: gmii_txd=0, gmii_tx_en=0, gmii_tx_er=0, req_ready=0, grant=0, underrun=0, frame_cnt=0.
- Round-robin pointer resets to NREQ-1, so source 0 wins first.
- Reset mid-frame: outputs take their reset values on the next edge. No tail or gap is sent.
- All gmii_* outputs are registered. req_ready is combinational from state and grant.
- State IDLE: when link_up=1 and any req_valid, grant the first asserted source searching upward (mod NREQ) from pointer+1. Latch grant, update the pointer, go PREAMBLE with cnt=0. The first 0x55 appears on gmii_txd at the next edge.
- Simultaneous requests resolve by pointer only. Requests arriving while not IDLE wait.
- State PREAMBLE: drive 8 cycles with tx_en=1. txd=0x55 for cnt 0..6 and 0xD5 for cnt 7. Then go DATA.
- PREAMBLE ignores req_valid; req_ready=0.
- State DATA: req_ready[g]=1 for the granted source only.
- DATA, normal byte: each valid&ready byte is registered to txd with tx_en=1.
  - Byte contiguity rule: the first payload byte is output on the cycle directly after the SFD, with no gaps between payload bytes.
- DATA, req_last accepted: go IFG; frame_cnt increments by 1 on that edge.
- DATA, req_valid[g]=0 or link_up=0 (underrun/abort):
  - Output one cycle of tx_en=1, tx_er=1, txd=0x00, and pulse underrun.
  - Go DROP; frame_cnt is not incremented.
- PREAMBLE with link_up=0: same abort handling as DATA.
- State DROP:
  - tx_en=0; req_ready[g]=1 so the source's remaining bytes are discarded.
  - Exit to IFG on the cycle a byte with req_last is accepted.
  - If req_last and valid occur on the same cycle as the abort, exit to IFG directly.
  - link_up state does not affect DROP.
- State IFG: tx_en=0, grant held, req_ready=0. Count so that, with a request pending, tx_en is low for exactly IFG_CYCLES cycles between the last frame byte and the next 0x55. Then go IDLE and clear grant.
- An 8+L-byte on-wire frame holds tx_en high for exactly 8+L consecutive cycles.
- Single-byte payload (valid&last on the first DATA cycle) is legal.
- gmii_tx_er is 0 except on the abort cycle.

Test Plan:
1. link_up=1; src0 sends 3 bytes 0xDA,0x02,0x03, last on 0x03.
   -> txd = 55×7, D5, DA, 02, 03 with tx_en high 11 cycles; tx_er=0; frame_cnt=1; grant=01 during the frame.
2. NREQ=2, both sources continuously offer 4-byte frames.
   -> grants alternate 0,1,0,1; tx_en low exactly 12 cycles between frames; frame_cnt=4 after 4 frames.
3. src0 drops valid after 2 payload bytes, then resumes 3 bytes with last on the 3rd.
   -> one cycle of tx_en=1, tx_er=1, txd=00, underrun pulse; those 3 bytes are accepted with tx_en=0; frame_cnt unchanged; 12-cycle gap follows.
4. link_up=0 with req_valid=1 for 50 cycles, then link_up=1.
   -> tx_en=0 and grant=0 throughout; preamble starts the cycle after link_up rises.
5. rst asserted for 1 cycle during DATA of a frame.
   -> next edge: all outputs zero, frame_cnt=0; next grant goes to src0 even if src1 owned the aborted frame.
6. IFG_CYCLES=2, back-to-back 1-byte frames from src1.
   -> tx_en high 9 cycles, low 2, high 9; frame_cnt 0xFFFF wraps to 0x0000 when preloaded via 65535 frames or a forced value.

Source files
------------

// File: rtl/gmii_tx_arbiter.sv
// rtl/gmii_tx_arbiter.sv - Round-robin GMII transmit arbiter with preamble/SFD and inter-frame gap generation
//
// Shares one GMII transmit port among NREQ frame sources. Each source
// supplies a complete frame (destination MAC through FCS); the block adds
// the preamble and SFD in front of it and enforces the inter-frame gap.
//
// Ports:
//   clk, rst                 GMII tx clock, synchronous active-high reset
//   link_up                  PCS/PMA ready; no new grant while low
//   req_valid/data/last      per-source byte stream (source i on data[8i+7:8i])
//   req_ready                per-source accept, combinational from state and grant
//   grant                    one-hot owner of the current frame, 0 when idle
//   gmii_txd/tx_en/tx_er     registered GMII transmit outputs
//   underrun                 one-cycle pulse when a frame is aborted
//   frame_cnt                completed (non-aborted) frames, wrapping

module gmii_tx_arbiter #(
    parameter int NREQ       = 2,
    parameter int IFG_CYCLES = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              link_up,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        gmii_txd,
    output logic              gmii_tx_en,
    output logic              gmii_tx_er,
    output logic              underrun,
    output logic [15:0]       frame_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(IFG_CYCLES + 8);

    localparam logic [CW-1:0] PRE_LAST = CW'(7);
    // The IFG state lasts IFG_CYCLES-1 cycles; the IDLE grant cycle supplies
    // the final low cycle before the first preamble byte reaches the wire.
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP,
        S_IFG
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     ptr_q;
    logic [NREQ-1:0]   grant_q;
    logic [7:0]        txd_q;
    logic              tx_en_q;
    logic              tx_er_q;
    logic              underrun_q;
    logic [15:0]       frame_cnt_q;

    logic              pick_found_d;
    logic [PW-1:0]     pick_idx_d;
    logic [NREQ-1:0]   pick_oh_d;

    logic              g_valid;
    logic              g_last;
    logic [7:0]        g_data;

    // Round-robin search upward from the source after the last winner.
    always_comb begin
        pick_found_d = 1'b0;
        pick_idx_d   = ptr_q;
        for (int i = 1; i <= NREQ; i++) begin
            if (!pick_found_d && req_valid[(int'(ptr_q) + i) % NREQ]) begin
                pick_found_d = 1'b1;
                pick_idx_d   = PW'((int'(ptr_q) + i) % NREQ);
            end
        end
        pick_oh_d             = '0;
        pick_oh_d[pick_idx_d] = pick_found_d;
    end

    // Stream of the currently granted source.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[8*i +: 8];
            end
        end
    end

    // DROP keeps accepting so an aborted source can flush its remaining bytes.
    assign req_ready = ((state_q == S_DATA) || (state_q == S_DROP)) ? grant_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ptr_q       <= PW'(NREQ - 1);
            grant_q     <= '0;
            txd_q       <= 8'h00;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            txd_q      <= 8'h00;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            underrun_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (link_up && pick_found_d) begin
                        grant_q <= pick_oh_d;
                        ptr_q   <= pick_idx_d;
                        cnt_q   <= '0;
                        state_q <= S_PREAMBLE;
                    end
                end

                S_PREAMBLE: begin
                    if (!link_up) begin
                        tx_en_q    <= 1'b1;
                        tx_er_q    <= 1'b1;
                        underrun_q <= 1'b1;
                        state_q    <= S_DROP;
                    end else begin
                        tx_en_q <= 1'b1;
                        txd_q   <= (cnt_q == PRE_LAST) ? 8'hD5 : 8'h55;
                        if (cnt_q == PRE_LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_DATA;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (!link_up || !g_valid) begin
                        // Abort: mark the frame bad on the wire. A last byte
                        // accepted on this same cycle ends the frame outright.
                        tx_en_q    <= 1'b1;
                        tx_er_q    <= 1'b1;
                        underrun_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= (g_valid && g_last) ? S_IFG : S_DROP;
                    end else begin
                        tx_en_q <= 1'b1;
                        txd_q   <= g_data;
                        if (g_last) begin
                            frame_cnt_q <= frame_cnt_q + 16'h0001;
                            cnt_q       <= '0;
                            state_q     <= S_IFG;
                        end
                    end
                end

                S_DROP: begin
                    if (g_valid && g_last) begin
                        cnt_q   <= '0;
                        state_q <= S_IFG;
                    end
                end

                S_IFG: begin
                    if (cnt_q == IFG_LAST) begin
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    grant_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant      = grant_q;
    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
    assign underrun   = underrun_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// tb/tb_gmii_tx_arbiter.sv - Randomized self-checking bench for gmii_tx_arbiter against a frame-level model

module tb_gmii_tx_arbiter;

    localparam int N   = 3;
    localparam int IFG = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic           link_up;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic [7:0]     gmii_txd;
    logic           gmii_tx_en;
    logic           gmii_tx_er;
    logic           underrun;
    logic [15:0]    frame_cnt;

    // Second instance at the minimum gap setting.
    logic [1:0]     req_valid2;
    logic [1:0]     req_ready2;
    logic [1:0]     grant2;
    logic [7:0]     gmii_txd2;
    logic           gmii_tx_en2;
    logic           gmii_tx_er2;
    logic           underrun2;
    logic [15:0]    frame_cnt2;

    always #4 clk = ~clk;

    gmii_tx_arbiter #(.NREQ(N), .IFG_CYCLES(IFG)) dut (
        .clk(clk), .rst(rst), .link_up(link_up),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .underrun(underrun), .frame_cnt(frame_cnt)
    );

    gmii_tx_arbiter #(.NREQ(2), .IFG_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .link_up(1'b1),
        .req_valid(req_valid2), .req_data(16'hA5A5), .req_last(2'b11),
        .req_ready(req_ready2), .grant(grant2),
        .gmii_txd(gmii_txd2), .gmii_tx_en(gmii_tx_en2), .gmii_tx_er(gmii_tx_er2),
        .underrun(underrun2), .frame_cnt(frame_cnt2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source frame storage: abk = index of the byte the source withholds (abort), -1 for none.
    logic [7:0] fr_data [N][4][8];
    int         fr_len  [N][4];
    int         fr_abk  [N][4];
    int         nfr     [N];
    int         fi      [N];
    int         acc     [N];
    bit         abs_seen[N];
    bit         fire_q  [N];
    bit         lfire_q [N];

    // Frame-level expectations.
    logic [8:0] exp_bytes[$];
    int         exp_len[$];
    int         exp_src[$];
    int         exp_gap[$];
    int         m_ptr;
    int         exp_good;
    int         exp_unders;
    bit         m_prev_abort;
    int         m_prev_rem;

    // Monitor state.
    bit         mon_en;
    bit         in_burst;
    logic [8:0] burst[$];
    logic [N-1:0] burst_grant;
    int         low_cnt;
    int         under_seen;
    bit         rec2;
    bit         q2[$];

    // Every source with frames keeps requesting, so frames leave in pure
    // round-robin order over the sources that still have frames.
    task automatic plan_batch();
        int  k[N];
        int  s;
        int  f;
        bit  found;
        bit  first;
        s     = 0;
        first = 1'b1;
        for (int i = 0; i < N; i++) k[i] = 0;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int j = 1; j <= N; j++) begin
                int c;
                c = (m_ptr + j) % N;
                if (!found && k[c] < nfr[c]) begin
                    found = 1'b1;
                    s     = c;
                end
            end
            if (found) begin
                m_ptr = s;
                f     = k[s];
                k[s]++;
                if (first) exp_gap.push_back(-1);
                else if (m_prev_abort) exp_gap.push_back(IFG + m_prev_rem);
                else exp_gap.push_back(IFG);
                first = 1'b0;
                for (int b = 0; b < 7; b++) exp_bytes.push_back(9'h055);
                exp_bytes.push_back(9'h0D5);
                if (fr_abk[s][f] < 0) begin
                    for (int b = 0; b < fr_len[s][f]; b++) exp_bytes.push_back({1'b0, fr_data[s][f][b]});
                    exp_len.push_back(8 + fr_len[s][f]);
                    exp_good++;
                    m_prev_abort = 1'b0;
                end else begin
                    for (int b = 0; b < fr_abk[s][f]; b++) exp_bytes.push_back({1'b0, fr_data[s][f][b]});
                    exp_bytes.push_back(9'h100);
                    exp_len.push_back(9 + fr_abk[s][f]);
                    exp_unders++;
                    m_prev_abort = 1'b1;
                    m_prev_rem   = fr_len[s][f] - fr_abk[s][f];
                end
                exp_src.push_back(s);
            end
        end
    endtask

    task automatic compare_burst();
        int len;
        int src;
        if (exp_len.size() == 0) begin
            check("unexpected_burst", burst.size(), 0);
            return;
        end
        len = exp_len.pop_front();
        src = exp_src.pop_front();
        void'(exp_gap.pop_front());
        check("burst_len", burst.size(), len);
        check("burst_grant", burst_grant, 1 << src);
        for (int b = 0; b < len; b++) begin
            logic [8:0] eb;
            eb = exp_bytes.pop_front();
            if (b < burst.size()) check("burst_byte", burst[b], eb);
        end
    endtask

    task automatic monitor();
        if (underrun) under_seen++;
        if (gmii_tx_en) begin
            if (!in_burst) begin
                in_burst    = 1'b1;
                burst_grant = grant;
                burst.delete();
                if (exp_gap.size() > 0 && exp_gap[0] >= 0) check("ifg_gap", low_cnt, exp_gap[0]);
            end
            burst.push_back({gmii_tx_er, gmii_txd});
        end else begin
            check("tx_er_idle", gmii_tx_er, 1'b0);
            if (in_burst) begin
                in_burst = 1'b0;
                compare_burst();
                low_cnt = 0;
            end
            low_cnt++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (fire_q[i]) begin
                if (lfire_q[i]) begin
                    fi[i]++;
                    acc[i]      = 0;
                    abs_seen[i] = 1'b0;
                end else begin
                    acc[i]++;
                end
            end
            if (underrun && grant[i]) abs_seen[i] = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (fi[i] < nfr[i]) begin
                int f;
                f = fi[i];
                req_valid[i]       = !(grant[i] && fr_abk[i][f] >= 0 && acc[i] == fr_abk[i][f] && !abs_seen[i]);
                req_data[8*i +: 8] = fr_data[i][f][acc[i]];
                req_last[i]        = (acc[i] == fr_len[i][f] - 1);
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
            fire_q[i]  = req_valid[i] && req_ready[i];
            lfire_q[i] = fire_q[i] && req_last[i];
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (mon_en) monitor();
        if (rec2) q2.push_back(gmii_tx_en2);
        drive();
    endtask

    function automatic bit busy();
        bit b;
        b = 1'b0;
        for (int i = 0; i < N; i++) if (fi[i] < nfr[i]) b = 1'b1;
        return b;
    endfunction

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            nfr[i] = 0; fi[i] = 0; acc[i] = 0;
            abs_seen[i] = 1'b0; fire_q[i] = 1'b0; lfire_q[i] = 1'b0;
        end
    endtask

    task automatic run_batch(input int maxc);
        int c;
        c = 0;
        while (c < maxc && (exp_len.size() > 0 || in_burst || busy())) begin
            step();
            c++;
        end
        if (c >= maxc) check("batch_timeout", 1, 0);
        repeat (IFG + 4) step();
    endtask

    task automatic load_random();
        clear_sources();
        for (int i = 0; i < N; i++) begin
            nfr[i] = $urandom_range(0, 3);
            for (int f = 0; f < nfr[i]; f++) begin
                fr_len[i][f] = $urandom_range(1, 8);
                fr_abk[i][f] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, fr_len[i][f] - 1) : -1;
                for (int b = 0; b < 8; b++) fr_data[i][f][b] = 8'($urandom);
            end
        end
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int rv[$];
        int rl[$];
        rst        = 1'b1;
        link_up    = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        req_valid2 = 2'b00;
        mon_en     = 1'b0;
        rec2       = 1'b0;
        clear_sources();
        repeat (3) step();
        check("rst_txd", gmii_txd, 8'h00);
        check("rst_tx_en", gmii_tx_en, 1'b0);
        check("rst_tx_er", gmii_tx_er, 1'b0);
        check("rst_req_ready", req_ready, '0);
        check("rst_grant", grant, '0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_frame_cnt", frame_cnt, 16'h0000);
        rst          = 1'b0;
        m_ptr        = N - 1;
        exp_good     = 0;
        exp_unders   = 0;
        under_seen   = 0;
        m_prev_abort = 1'b0;
        m_prev_rem   = 0;
        in_burst     = 1'b0;
        low_cnt      = 0;
        mon_en       = 1'b1;

        // Minimum-gap instance: back-to-back one-byte frames from source 1.
        req_valid2 = 2'b10;
        rec2       = 1'b1;
        repeat (40) step();
        rec2       = 1'b0;
        req_valid2 = 2'b00;
        foreach (q2[i]) begin
            if (rv.size() > 0 && rv[rv.size()-1] == int'(q2[i])) rl[rl.size()-1]++;
            else begin rv.push_back(int'(q2[i])); rl.push_back(1); end
        end
        check("ifg2_runs", rl.size() >= 4, 1);
        if (rl.size() >= 4) begin
            check("ifg2_high1_val", rv[1], 1);
            check("ifg2_high1_len", rl[1], 9);
            check("ifg2_low_len", rl[2], 2);
            check("ifg2_high2_len", rl[3], 9);
        end

        // Single short frame from source 0.
        clear_sources();
        nfr[0] = 1; fr_len[0][0] = 3; fr_abk[0][0] = -1;
        fr_data[0][0][0] = 8'hDA; fr_data[0][0][1] = 8'h02; fr_data[0][0][2] = 8'h03;
        plan_batch();
        run_batch(200);
        check("t1_frame_cnt", frame_cnt, 16'd1);

        // Directed abort after two payload bytes, then a clean frame from source 1.
        clear_sources();
        nfr[0] = 1; fr_len[0][0] = 5; fr_abk[0][0] = 2;
        nfr[1] = 1; fr_len[1][0] = 4; fr_abk[1][0] = -1;
        for (int b = 0; b < 8; b++) begin
            fr_data[0][0][b] = 8'(8'h10 + b);
            fr_data[1][0][b] = 8'(8'h20 + b);
        end
        plan_batch();
        run_batch(400);
        check("t3_frame_cnt", frame_cnt, 16'(exp_good));

        // Randomized batches.
        for (int r = 0; r < 8; r++) begin
            load_random();
            plan_batch();
            run_batch(4000);
        end
        check("rand_frame_cnt", frame_cnt, 16'(exp_good));
        check("rand_underruns", under_seen, exp_unders);

        // Link down holds everything off; preamble follows the link coming up.
        link_up = 1'b0;
        clear_sources();
        nfr[1] = 1; fr_len[1][0] = 2; fr_abk[1][0] = -1;
        fr_data[1][0][0] = 8'h77; fr_data[1][0][1] = 8'h88;
        plan_batch();
        bad = 0;
        repeat (50) begin
            step();
            if (gmii_tx_en || grant != '0) bad++;
        end
        check("link_down_quiet", bad, 0);
        link_up = 1'b1;
        step();
        check("link_up_grant", grant, 3'b010);
        check("link_up_tx_en_wait", gmii_tx_en, 1'b0);
        step();
        check("link_up_preamble", {gmii_tx_en, gmii_txd}, 9'h155);
        run_batch(200);

        // Reset in the middle of a frame owned by source 1.
        mon_en = 1'b0;
        clear_sources();
        nfr[1] = 1; fr_len[1][0] = 8; fr_abk[1][0] = -1;
        for (int b = 0; b < 8; b++) fr_data[1][0][b] = 8'(8'h40 + b);
        bad = 0;
        while (bad < 100 && !(req_ready[1] && acc[1] >= 2)) begin
            step();
            bad++;
        end
        check("t5_reach_data", bad < 100, 1);
        rst = 1'b1;
        clear_sources();
        step();
        check("t5_txd", gmii_txd, 8'h00);
        check("t5_tx_en", gmii_tx_en, 1'b0);
        check("t5_grant", grant, '0);
        check("t5_req_ready", req_ready, '0);
        check("t5_frame_cnt", frame_cnt, 16'h0000);
        rst = 1'b0;
        exp_bytes.delete(); exp_len.delete(); exp_src.delete(); exp_gap.delete();
        m_ptr = N - 1; exp_good = 0; exp_unders = 0; under_seen = 0;
        m_prev_abort = 1'b0; in_burst = 1'b0; low_cnt = 0;
        mon_en = 1'b1;
        nfr[0] = 1; fr_len[0][0] = 2; fr_abk[0][0] = -1;
        nfr[1] = 1; fr_len[1][0] = 3; fr_abk[1][0] = -1;
        for (int b = 0; b < 8; b++) begin
            fr_data[0][0][b] = 8'(8'hA0 + b);
            fr_data[1][0][b] = 8'(8'hB0 + b);
        end
        plan_batch();
        run_batch(300);
        check("t5_after_frame_cnt", frame_cnt, 16'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
